// File: rtl/key_debouncer_if.sv
// Pushbutton bundle between the raw KEY pins and the debounced per-key event outputs.
interface key_debouncer_if #(
  parameter int unsigned N_KEYS = 4
) ();
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchroniser, debounce FSM and press/release pulse generator for active-low pushbuttons.
// Define KEY_AUTOREPEAT_EN to build the per-key auto-repeat timer; otherwise key_repeat is 0.
module key_debouncer #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input logic           CLOCK_50,
  input logic           reset,
  key_debouncer_if.slave keys
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gen_bad_param
    $error("key_debouncer: cycle-count parameters must be >= 1");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync_q;
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CntW-1:0]   cnt_q   [N_KEYS];
  logic [CntW-1:0]   cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmrW   = $clog2(RepMax + 1);
  localparam logic [TmrW-1:0] DelayLast = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] RateLast  = TmrW'(REPEAT_RATE - 1);

  logic [TmrW-1:0]   tmr_q [N_KEYS];
  logic [TmrW-1:0]   tmr_d [N_KEYS];
  // first_q selects the initial delay before the first repeat versus the steady rate.
  logic [N_KEYS-1:0] first_q, first_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;
`endif

  always_comb begin
    for (int i = 0; i < int'(N_KEYS); i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      level_d[i]   = level_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      tmr_d[i]     = tmr_q[i];
      first_d[i]   = first_q[i];
      repeat_d[i]  = 1'b0;
`endif
      unique case (state_q[i])
        StIdle: begin
          if (sync_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (!sync_q[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StPressed;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            tmr_d[i]   = '0;
            first_d[i] = 1'b1;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StPressed: begin
          if (!sync_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (tmr_q[i] == (first_q[i] ? DelayLast : RateLast)) begin
            repeat_d[i] = 1'b1;
            tmr_d[i]    = '0;
            first_d[i]  = 1'b0;
          end else begin
            tmr_d[i] = tmr_q[i] + TmrW'(1);
          end
`endif
        end
        StReleaseWait: begin
          if (sync_q[i]) begin
            // Bounce back to pressed: restart the repeat delay from scratch.
            state_d[i] = StPressed;
`ifdef KEY_AUTOREPEAT_EN
            tmr_d[i]   = '0;
            first_d[i] = 1'b1;
`endif
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]   = StIdle;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            tmr_d[i]     = '0;
            first_d[i]   = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      state_q   <= '{default: StIdle};
      cnt_q     <= '{default: '0};
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= ~keys.KEY;
      sync_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmr_q    <= '{default: '0};
      first_q  <= '0;
      repeat_q <= '0;
    end else begin
      tmr_q    <= tmr_d;
      first_q  <= first_d;
      repeat_q <= repeat_d;
    end
  end

  assign keys.key_repeat = repeat_q;
`else
  assign keys.key_repeat = '0;
`endif

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_key_debouncer;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic CLOCK_50;
  logic reset;
  int   vectors;
  int   miscompares;

  key_debouncer_if #(.N_KEYS(4)) kif ();

  key_debouncer #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .keys     (kif)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One rising edge, then settle 1 time unit before driving or sampling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".level"},   kif.key_level,   4'b0000);
    check({tag, ".press"},   kif.key_press,   4'b0000);
    check({tag, ".release"}, kif.key_release, 4'b0000);
    check({tag, ".repeat"},  kif.key_repeat,  4'b0000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    kif.KEY     = 4'hF;
    reset       = 1'b1;

    // Reset with keys released, then a reset pulse while all keys are held.
    tick(3);
    check_all_zero("rst_released");
    reset = 1'b0;
    tick(2);
    kif.KEY = 4'h0;
    reset   = 1'b1;
    tick(1);
    check_all_zero("rst_held");
    reset = 1'b0;
    tick(6);
    check("held_thru_rst.press_early", kif.key_press, 4'h0);
    tick(1);
    check("held_thru_rst.press", kif.key_press, 4'hF);
    check("held_thru_rst.level", kif.key_level, 4'hF);
    tick(1);
    check("held_thru_rst.press_once", kif.key_press, 4'h0);
    check("held_thru_rst.level_hold", kif.key_level, 4'hF);

    // Release every key.
    kif.KEY = 4'hF;
    tick(6);
    check("rel_all.release_early", kif.key_release, 4'h0);
    check("rel_all.level_early", kif.key_level, 4'hF);
    tick(1);
    check("rel_all.release", kif.key_release, 4'hF);
    check("rel_all.level", kif.key_level, 4'h0);
    tick(1);
    check("rel_all.release_once", kif.key_release, 4'h0);

    // Single key 1 press.
    kif.KEY = 4'b1101;
    tick(6);
    check("k1.press_early", kif.key_press, 4'b0000);
    check("k1.level_early", kif.key_level, 4'b0000);
    tick(1);
    check("k1.press", kif.key_press, 4'b0010);
    check("k1.level", kif.key_level, 4'b0010);
    tick(1);
    check("k1.press_once", kif.key_press, 4'b0000);
    check("k1.level_hold", kif.key_level, 4'b0010);

    // Key 1 bounces on release: high, high, low, then stays high.
    kif.KEY = 4'hF;
    tick(2);
    check("k1_bounce.level_a", kif.key_level, 4'b0010);
    kif.KEY = 4'b1101;
    tick(1);
    check("k1_bounce.level_b", kif.key_level, 4'b0010);
    kif.KEY = 4'hF;
    for (int t = 1; t <= 6; t++) begin
      tick(1);
      check("k1_bounce.level_wait", kif.key_level, 4'b0010);
      check("k1_bounce.release_wait", kif.key_release, 4'b0000);
    end
    tick(1);
    check("k1_bounce.release", kif.key_release, 4'b0010);
    check("k1_bounce.level_off", kif.key_level, 4'b0000);
    tick(1);
    check("k1_bounce.release_once", kif.key_release, 4'b0000);

    // Key 2 glitches low for three cycles: must be rejected.
    kif.KEY = 4'b1011;
    tick(3);
    kif.KEY = 4'hF;
    for (int t = 0; t < 10; t++) begin
      check("k2_glitch.press", kif.key_press, 4'b0000);
      check("k2_glitch.level", kif.key_level, 4'b0000);
      tick(1);
    end

    // Keys 0 and 3 together.
    kif.KEY = 4'b0110;
    tick(6);
    check("k03.press_early", kif.key_press, 4'b0000);
    tick(1);
    check("k03.press", kif.key_press, 4'b1001);
    check("k03.level", kif.key_level, 4'b1001);
    tick(1);
    check("k03.press_once", kif.key_press, 4'b0000);
    check("k03.level_hold", kif.key_level, 4'b1001);
    kif.KEY = 4'hF;
    tick(8);
    check("k03.level_off", kif.key_level, 4'b0000);

    // Key 0 held 30 cycles after its press; repeats at press+10, +13, +16, ...
    kif.KEY = 4'b1110;
    tick(7);
    check("k0_hold.press", kif.key_press, 4'b0001);
    check("k0_hold.repeat_at_press", kif.key_repeat, 4'b0000);
    for (int j = 1; j <= 30; j++) begin
      logic [3:0] exp_rep;
      tick(1);
      exp_rep = (AutoRep && j >= 10 && ((j - 10) % 3) == 0) ? 4'b0001 : 4'b0000;
      check($sformatf("k0_hold.repeat_j%0d", j), kif.key_repeat, exp_rep);
      check("k0_hold.level", kif.key_level, 4'b0001);
      check("k0_hold.press_quiet", kif.key_press, 4'b0000);
    end
    reset = 1'b1;
    tick(1);
    check("k0_hold_rst.repeat", kif.key_repeat, 4'b0000);
    check("k0_hold_rst.level", kif.key_level, 4'b0000);
    reset   = 1'b0;
    kif.KEY = 4'hF;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
